// File: rtl/kanagawa_register_fifo_interleaved.sv
// Show-ahead register FIFO built from LANES round-robin banks of LANE_DEPTH entries each.
// Provides occupancy count, almost_full, and sticky overflow/underflow flags. Reset is synchronous.
module kanagawa_register_fifo_interleaved #(
  parameter int WIDTH             = 32,
  parameter int LANES             = 2,
  parameter int LANE_DEPTH        = 1,
  parameter int ALMOST_FULL_LEVEL = LANES * LANE_DEPTH - 1,
  localparam int CAPACITY         = LANES * LANE_DEPTH,
  localparam int CW               = $clog2(CAPACITY + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             almost_full,
  input  logic             rdreq,
  output logic             empty,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    count,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam logic [CW:0] AF_LEVEL = (CW + 1)'(ALMOST_FULL_LEVEL);

  logic [WIDTH-1:0] mem_q [LANES][LANE_DEPTH];
  logic [DW-1:0]    head_q [LANES];
  logic [DW-1:0]    tail_q [LANES];
  logic [LW-1:0]    wr_lane_q, wr_lane_d;
  logic [LW-1:0]    rd_lane_q, rd_lane_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             write_ok, read_ok;

  function automatic logic [LW-1:0] lane_inc(input logic [LW-1:0] l);
    return (l == LW'(LANES - 1)) ? '0 : l + 1'b1;
  endfunction

  function automatic logic [DW-1:0] ptr_inc(input logic [DW-1:0] p);
    return (p == DW'(LANE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lanes fill and drain in the same rotation, so bank occupancies differ by at most one and
  // the global count alone decides full/empty.
  assign full          = (count_q == CW'(CAPACITY));
  assign empty         = (count_q == '0);
  assign almost_full   = ({1'b0, count_q} >= AF_LEVEL);
  assign count         = count_q;
  assign q             = mem_q[rd_lane_q][head_q[rd_lane_q]];
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  assign write_ok = wrreq & ~full;
  assign read_ok  = rdreq & ~empty;

  always_comb begin
    wr_lane_d = write_ok ? lane_inc(wr_lane_q) : wr_lane_q;
    rd_lane_d = read_ok  ? lane_inc(rd_lane_q) : rd_lane_q;
    count_d   = count_q;
    case ({write_ok, read_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_lane_q   <= '0;
      rd_lane_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      wr_lane_q <= wr_lane_d;
      rd_lane_q <= rd_lane_d;
      count_q   <= count_d;
      if (write_ok) tail_q[wr_lane_q] <= ptr_inc(tail_q[wr_lane_q]);
      if (read_ok)  head_q[rd_lane_q] <= ptr_inc(head_q[rd_lane_q]);
      if (wrreq && full)  overflow_q  <= 1'b1;
      if (rdreq && empty) underflow_q <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (!rst && write_ok) mem_q[wr_lane_q][tail_q[wr_lane_q]] <= data;
  end

`ifndef NO_DYNAMIC_ASSERTS
  always @(posedge clock) begin
    if (!rst) begin
      assert (!(wrreq && full))  else $warning("overflow: write request while full");
      assert (!(rdreq && empty)) else $warning("underflow: read request while empty");
    end
  end
`endif

endmodule

// File: tb/tb_kanagawa_register_fifo_interleaved.sv
// Bench for the interleaved register FIFO: directed plan on a 3x2 instance, random traffic on 1x1 and 4x1.
// A negedge monitor per instance checks every output against a queue-based reference model.
module tb_kanagawa_register_fifo_interleaved;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L   = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
    localparam int D   = (g == 0) ? 2 : 1;
    localparam int CAP = L * D;
    localparam int CW  = $clog2(CAP + 1);

    logic          rst_s = 1'b1;
    logic          wr_s  = 1'b0;
    logic          rd_s  = 1'b0;
    logic [7:0]    din_s = 8'h00;
    logic          full_o, af_o, empty_o, ovf_o, unf_o;
    logic [7:0]    q_o;
    logic [CW-1:0] cnt_o;
    bit            done = 1'b0;

    logic [7:0] exp_q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    kanagawa_register_fifo_interleaved #(
      .WIDTH(8), .LANES(L), .LANE_DEPTH(D)
    ) u_dut (
      .clock(clk), .rst(rst_s), .wrreq(wr_s), .data(din_s),
      .full(full_o), .almost_full(af_o), .rdreq(rd_s), .empty(empty_o),
      .q(q_o), .count(cnt_o), .overflow_err(ovf_o), .underflow_err(unf_o)
    );

    // Reference model: a plain queue of stored words plus two sticky bits.
    always @(negedge clk) begin : monitor
      int n;
      bit wok, rok;
      if (rst_s) begin
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        n = exp_q.size();
        chk($sformatf("g%0d count", g), 32'(cnt_o), n);
        chk($sformatf("g%0d empty", g), 32'(empty_o), 32'(n == 0));
        chk($sformatf("g%0d full", g), 32'(full_o), 32'(n == CAP));
        chk($sformatf("g%0d almost_full", g), 32'(af_o), 32'(n >= CAP - 1));
        chk($sformatf("g%0d overflow_err", g), 32'(ovf_o), 32'(m_ovf));
        chk($sformatf("g%0d underflow_err", g), 32'(unf_o), 32'(m_unf));
        if (n > 0) chk($sformatf("g%0d q", g), 32'(q_o), 32'(exp_q[0]));
        wok = wr_s && (n < CAP);
        rok = rd_s && (n > 0);
        if (wr_s && n == CAP) m_ovf = 1'b1;
        if (rd_s && n == 0)   m_unf = 1'b1;
        if (rok) void'(exp_q.pop_front());
        if (wok) exp_q.push_back(din_s);
      end
    end

    if (g == 0) begin : directed
      task automatic put(input logic w, input logic r, input logic [7:0] d);
        wr_s  = w;
        rd_s  = r;
        din_s = d;
        cyc();
        wr_s  = 1'b0;
        rd_s  = 1'b0;
      endtask

      initial begin
        rst_s = 1'b1;
        cyc();
        cyc();
        rst_s = 1'b0;
        chk("reset empty", 32'(empty_o), 1);
        chk("reset full", 32'(full_o), 0);
        chk("reset almost_full", 32'(af_o), 0);
        chk("reset count", 32'(cnt_o), 0);

        for (int i = 0; i < 6; i++) begin
          put(1'b1, 1'b0, 8'(16 + i));
          if (i == 0) chk("first write empty", 32'(empty_o), 0);
          if (i == 3) chk("count4 almost_full", 32'(af_o), 0);
          if (i == 4) chk("count5 almost_full", 32'(af_o), 1);
          if (i == 4) chk("count5 full", 32'(full_o), 0);
          chk("fill head", 32'(q_o), 32'h10);
        end
        chk("fill full", 32'(full_o), 1);
        chk("fill count", 32'(cnt_o), 6);

        for (int i = 0; i < 6; i++) begin
          if (!empty_o) chk("drain order", 32'(q_o), 32'(16 + i));
          put(1'b0, 1'b1, 8'h00);
        end
        chk("drain empty", 32'(empty_o), 1);
        chk("drain count", 32'(cnt_o), 0);
        chk("drain no overflow", 32'(ovf_o), 0);
        chk("drain no underflow", 32'(unf_o), 0);

        for (int i = 0; i < 6; i++) put(1'b1, 1'b0, 8'(16 + i));
        put(1'b1, 1'b1, 8'hAA);
        chk("full rw overflow", 32'(ovf_o), 1);
        chk("full rw count", 32'(cnt_o), 5);
        chk("full rw full", 32'(full_o), 0);
        chk("full rw head", 32'(q_o), 32'h11);
        put(1'b1, 1'b0, 8'hBB);
        chk("refill count", 32'(cnt_o), 6);
        for (int i = 0; i < 6; i++) put(1'b0, 1'b1, 8'h00);
        chk("post BB empty", 32'(empty_o), 1);

        put(1'b1, 1'b1, 8'h01);
        chk("empty rw underflow", 32'(unf_o), 1);
        chk("empty rw count", 32'(cnt_o), 1);
        chk("empty rw head", 32'(q_o), 32'h01);
        for (int i = 0; i < 10; i++) put(1'b1, 1'b1, 8'(2 + i));
        chk("stream count", 32'(cnt_o), 1);
        chk("stream head", 32'(q_o), 32'h0B);
        put(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 4; i++) put(1'b1, 1'b0, 8'(32 + i));
        chk("pre-reset count", 32'(cnt_o), 4);
        rst_s = 1'b1;
        wr_s  = 1'b1;
        rd_s  = 1'b1;
        din_s = 8'h24;
        cyc();
        rst_s = 1'b0;
        wr_s  = 1'b0;
        rd_s  = 1'b0;
        chk("mid reset count", 32'(cnt_o), 0);
        chk("mid reset empty", 32'(empty_o), 1);
        chk("mid reset overflow", 32'(ovf_o), 0);
        chk("mid reset underflow", 32'(unf_o), 0);
        put(1'b1, 1'b0, 8'h55);
        chk("after reset head", 32'(q_o), 32'h55);
        put(1'b0, 1'b1, 8'h00);
        chk("after reset drained", 32'(empty_o), 1);
        done = 1'b1;
      end
    end else begin : random
      initial begin
        rst_s = 1'b1;
        cyc();
        cyc();
        rst_s = 1'b0;
        for (int i = 0; i < 1000; i++) begin
          wr_s  = ($urandom_range(0, 1) == 1) && !full_o;
          rd_s  = ($urandom_range(0, 1) == 1) && !empty_o;
          din_s = 8'($urandom);
          cyc();
        end
        wr_s = 1'b0;
        rd_s = 1'b0;
        done = 1'b1;
      end
    end
  end

  initial begin
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(posedge clk);
      ok = gen_dut[0].done && gen_dut[1].done && gen_dut[2].done;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout stimulus_done=%0b required=1", ok);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
